// File: rtl/simd_pkg.sv
// Shared SIMD dispatch types: opcodes, the buffered instruction
// record, FSM states and the opcode legality helper.
package simd_pkg;

   localparam int MAX_LANES = 8;
   localparam int OP_W      = 3;
   localparam int DATA_W    = 8;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_OR  = 3'b010,
      OP_AND = 3'b011,
      OP_XOR = 3'b100
   } opcode_e;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ISSUE,
      ST_STALL
   } disp_state_e;

   // Mask is sized for the widest build; unused upper bits stay zero.
   typedef struct packed {
      logic [OP_W-1:0]      opcode;
      logic [DATA_W-1:0]    a;
      logic [DATA_W-1:0]    b;
      logic [MAX_LANES-1:0] mask;
   } instr_t;

   function automatic logic is_legal_opcode(
      input logic [OP_W-1:0] op
   );
      return op <= OP_XOR;
   endfunction

endpackage

// File: rtl/simd_if.sv
// Dispatcher bus: upstream instruction handshake, lane issue
// broadcast, lane completion pulses and status outputs.
interface simd_if #(
   parameter int LANES      = 4,
   parameter int FIFO_DEPTH = 4
);
   import simd_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic                in_valid;
   logic                in_ready;
   logic [OP_W-1:0]     in_opcode;
   logic [DATA_W-1:0]   in_a;
   logic [DATA_W-1:0]   in_b;
   logic [LANES-1:0]    in_mask;
   logic [LANES-1:0]    issue_valid;
   logic [OP_W-1:0]     issue_opcode;
   logic [DATA_W-1:0]   issue_a;
   logic [DATA_W-1:0]   issue_b;
   logic [LANES-1:0]    lane_done;
   logic                illegal_op;
   logic                credit_err;
   logic [CW-1:0]       fifo_count;

   modport master (
      output in_valid, in_opcode, in_a, in_b,
      output in_mask, lane_done,
      input  in_ready, issue_valid, issue_opcode,
      input  issue_a, issue_b, illegal_op,
      input  credit_err, fifo_count
   );

   modport slave (
      input  in_valid, in_opcode, in_a, in_b,
      input  in_mask, lane_done,
      output in_ready, issue_valid, issue_opcode,
      output issue_a, issue_b, illegal_op,
      output credit_err, fifo_count
   );

endinterface

// File: rtl/simd_fifo.sv
// Circular instruction buffer, DEPTH a power of two.
// Ports: push/wdata in, pop/rdata out (head), count of entries.
module simd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/simd_dispatch.sv
// In-order SIMD dispatcher with per-lane reservation credits.
// Ports: clk, reset, bus (simd_if slave: in/issue/done/status).
module simd_dispatch
   import simd_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int RS_SIZE    = 4
) (
   input logic  clk,
   input logic  reset,
   simd_if.slave bus
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int KW = $clog2(RS_SIZE + 1);
   localparam int IW = $bits(instr_t);

   disp_state_e state;

   instr_t        wr_instr;
   instr_t        head;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          legal;
   logic          blocked;
   logic          issue_now;
   logic          err_hit;

   logic [LANES-1:0]          issue_valid_q, issue_valid_d;
   logic [OP_W-1:0]           issue_op_q, issue_op_d;
   logic [DATA_W-1:0]         issue_a_q, issue_a_d;
   logic [DATA_W-1:0]         issue_b_q, issue_b_d;
   logic                      illegal_q, illegal_d;
   logic                      credit_err_q, credit_err_d;
   logic [LANES-1:0][KW-1:0]  credit_q, credit_d;

   always_comb begin
      wr_instr        = '0;
      wr_instr.opcode = bus.in_opcode;
      wr_instr.a      = bus.in_a;
      wr_instr.b      = bus.in_b;
      wr_instr.mask   = MAX_LANES'(bus.in_mask);
   end

   // No bypass: a full buffer refuses even when the head pops.
   assign bus.in_ready = count < CW'(FIFO_DEPTH);
   assign push         = bus.in_valid && bus.in_ready;

   simd_fifo #(
      .WIDTH (IW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (wr_instr),
      .rdata (head),
      .count (count)
   );

   // State is a pure function of the head and the credits.
   // An illegal head is always consumable, so it counts as ISSUE.
   always_comb begin
      state     = ST_EMPTY;
      pop       = 1'b0;
      issue_now = 1'b0;
      illegal_d = 1'b0;
      blocked   = 1'b0;
      legal     = is_legal_opcode(head.opcode)
                  && (head.mask != '0);
      for (int i = 0; i < LANES; i++) begin
         if (head.mask[i] && credit_q[i] == '0)
            blocked = 1'b1;
      end
      if (count != '0)
         state = (!legal || !blocked) ? ST_ISSUE : ST_STALL;
      unique case (state)
         ST_ISSUE: begin
            pop       = 1'b1;
            issue_now = legal;
            illegal_d = !legal;
         end
         ST_EMPTY, ST_STALL: ;
         default: ;
      endcase
   end

   always_comb begin
      issue_valid_d = '0;
      issue_op_d    = issue_op_q;
      issue_a_d     = issue_a_q;
      issue_b_d     = issue_b_q;
      if (issue_now) begin
         issue_valid_d = head.mask[LANES-1:0];
         issue_op_d    = head.opcode;
         issue_a_d     = head.a;
         issue_b_d     = head.b;
      end
   end

   // Issue and done on the same lane cancel out; a done at full
   // credit is dropped and flagged.
   always_comb begin
      credit_d = credit_q;
      err_hit  = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (issue_now && head.mask[i]
             && !bus.lane_done[i]) begin
            credit_d[i] = credit_q[i] - KW'(1);
         end else if (bus.lane_done[i]
             && !(issue_now && head.mask[i])) begin
            if (credit_q[i] == KW'(RS_SIZE))
               err_hit = 1'b1;
            else
               credit_d[i] = credit_q[i] + KW'(1);
         end
      end
      credit_err_d = credit_err_q | err_hit;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         issue_valid_q <= '0;
         issue_op_q    <= '0;
         issue_a_q     <= '0;
         issue_b_q     <= '0;
         illegal_q     <= 1'b0;
         credit_err_q  <= 1'b0;
         credit_q      <= {LANES{KW'(RS_SIZE)}};
      end else begin
         issue_valid_q <= issue_valid_d;
         issue_op_q    <= issue_op_d;
         issue_a_q     <= issue_a_d;
         issue_b_q     <= issue_b_d;
         illegal_q     <= illegal_d;
         credit_err_q  <= credit_err_d;
         credit_q      <= credit_d;
      end
   end

   assign bus.issue_valid  = issue_valid_q;
   assign bus.issue_opcode = issue_op_q;
   assign bus.issue_a      = issue_a_q;
   assign bus.issue_b      = issue_b_q;
   assign bus.illegal_op   = illegal_q;
   assign bus.credit_err   = credit_err_q;
   assign bus.fifo_count   = count;

endmodule

// File: tb/tb_simd_dispatch.sv
// Testbench for simd_dispatch: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_simd_dispatch;
   import simd_pkg::*;

   localparam int L  = 4;
   localparam int D  = 4;
   localparam int RS = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   simd_if #(.LANES(L), .FIFO_DEPTH(D)) bus ();

   simd_dispatch #(
      .LANES      (L),
      .FIFO_DEPTH (D),
      .RS_SIZE    (RS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int op;
      int a;
      int b;
      int mask;
   } m_ins_t;

   m_ins_t m_q[$];
   int     m_cred[L];
   bit     m_err;
   bit     m_ill;
   int     m_iv, m_op, m_a, m_b;

   int n_run  = 0;
   int n_fail = 0;

   // Reference: one edge of behaviour from the instruction rules.
   function automatic void model_edge();
      m_ins_t h;
      int     iss;
      bit     legal, ok, acc;
      if (reset) begin
         m_q.delete();
         foreach (m_cred[i]) m_cred[i] = RS;
         m_err = 0; m_ill = 0;
         m_iv = 0; m_op = 0; m_a = 0; m_b = 0;
         return;
      end
      acc   = bus.in_valid && (m_q.size() < D);
      iss   = 0;
      m_iv  = 0;
      m_ill = 0;
      if (m_q.size() > 0) begin
         h     = m_q[0];
         legal = (h.op <= 4) && (h.mask != 0);
         ok    = 1;
         for (int i = 0; i < L; i++)
            if (h.mask[i] && m_cred[i] == 0) ok = 0;
         if (!legal) begin
            m_ill = 1;
            void'(m_q.pop_front());
         end else if (ok) begin
            iss  = h.mask;
            m_iv = h.mask;
            m_op = h.op; m_a = h.a; m_b = h.b;
            void'(m_q.pop_front());
            for (int i = 0; i < L; i++)
               if (iss[i]) m_cred[i]--;
         end
      end
      for (int i = 0; i < L; i++) begin
         if (bus.lane_done[i]) begin
            if (iss[i]) m_cred[i]++;
            else if (m_cred[i] == RS) m_err = 1;
            else m_cred[i]++;
         end
      end
      if (acc)
         m_q.push_back('{op:   int'(bus.in_opcode),
                         a:    int'(bus.in_a),
                         b:    int'(bus.in_b),
                         mask: int'(bus.in_mask)});
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_in(input bit v, input int op,
                         input int a, input int b,
                         input int m);
      bus.in_valid  = v;
      bus.in_opcode = 3'(op);
      bus.in_a      = 8'(a);
      bus.in_b      = 8'(b);
      bus.in_mask   = 4'(m);
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.lane_done = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      set_in(0, 0, 0, 0, 0);
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n_run++;
      if (bus.fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d want 0",
                  bus.fifo_count);
      end
      n_run++;
      if (bus.issue_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_iv: got %b want 0000",
                  bus.issue_valid);
      end
      n_run++;
      if ({bus.illegal_op, bus.credit_err} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 00",
                  {bus.illegal_op, bus.credit_err});
      end
      n_run++;
      if ({bus.issue_opcode, bus.issue_a, bus.issue_b}
          !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_bus: got %h want 0",
                  {bus.issue_opcode, bus.issue_a, bus.issue_b});
      end
      n_run++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 1",
                  bus.in_ready);
      end
      for (int i = 0; i < L; i++) begin
         n_run++;
         if (int'(dut.credit_q[i]) !== RS) begin
            n_fail++;
            $display("FAIL reset_credit%0d: got %0d want %0d",
                     i, dut.credit_q[i], RS);
         end
      end
   endtask

   task automatic test_basic_issue();
      do_reset();
      set_in(1, 0, 3, 5, 4'b1111);
      step();
      idle();
      n_run++;
      if (bus.issue_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL basic_early: got %b want 0000",
                  bus.issue_valid);
      end
      step();
      n_run++;
      if (bus.issue_valid !== 4'b1111) begin
         n_fail++;
         $display("FAIL basic_iv: got %b want 1111",
                  bus.issue_valid);
      end
      n_run++;
      if ({bus.issue_opcode, bus.issue_a, bus.issue_b}
          !== {3'd0, 8'd3, 8'd5}) begin
         n_fail++;
         $display("FAIL basic_bus: got %h/%h/%h want 0/03/05",
                  bus.issue_opcode, bus.issue_a, bus.issue_b);
      end
      for (int i = 0; i < L; i++) begin
         n_run++;
         if (int'(dut.credit_q[i]) !== 3) begin
            n_fail++;
            $display("FAIL basic_credit%0d: got %0d want 3",
                     i, dut.credit_q[i]);
         end
      end
      step();
      n_run++;
      if (bus.issue_valid !== 4'b0000 ||
          bus.issue_a !== 8'd3) begin
         n_fail++;
         $display("FAIL basic_hold: got %b/%h want 0000/03",
                  bus.issue_valid, bus.issue_a);
      end
   endtask

   task automatic test_credit_stall();
      int n_iss;
      do_reset();
      n_iss = 0;
      for (int k = 0; k < 5; k++) begin
         set_in(1, 1, k, k + 1, 4'b0001);
         step();
         if (bus.issue_valid[0]) n_iss++;
      end
      idle();
      for (int k = 0; k < 6; k++) begin
         step();
         if (bus.issue_valid[0]) n_iss++;
      end
      n_run++;
      if (n_iss !== 4) begin
         n_fail++;
         $display("FAIL stall_issues: got %0d want 4", n_iss);
      end
      n_run++;
      if (bus.fifo_count !== 3'd1 ||
          bus.issue_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL stall_state: got %0d/%b want 1/0000",
                  bus.fifo_count, bus.issue_valid);
      end
      bus.lane_done = 4'b0001;
      step();
      bus.lane_done = 4'b0000;
      n_run++;
      if (bus.issue_valid !== 4'b0000 ||
          int'(dut.credit_q[0]) !== 1) begin
         n_fail++;
         $display("FAIL stall_done: got %b/%0d want 0000/1",
                  bus.issue_valid, dut.credit_q[0]);
      end
      step();
      n_run++;
      if (bus.issue_valid !== 4'b0001 ||
          bus.issue_a !== 8'd4 || bus.issue_b !== 8'd5) begin
         n_fail++;
         $display("FAIL stall_fifth: got %b/%h/%h want 0001/04/05",
                  bus.issue_valid, bus.issue_a, bus.issue_b);
      end
      n_run++;
      if (bus.fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL stall_drain: got %0d want 0",
                  bus.fifo_count);
      end
   endtask

   task automatic test_fifo_full();
      do_reset();
      set_in(1, 2, 1, 2, 4'b0001);
      for (int k = 0; k < 10; k++) begin
         n_run++;
         if (bus.in_ready !== (m_q.size() < D)) begin
            n_fail++;
            $display("FAIL full_ready%0d: got %b want %b",
                     k, bus.in_ready, m_q.size() < D);
         end
         step();
         n_run++;
         if (bus.fifo_count !== 3'(m_q.size())) begin
            n_fail++;
            $display("FAIL full_count%0d: got %0d want %0d",
                     k, bus.fifo_count, m_q.size());
         end
      end
      n_run++;
      if (bus.fifo_count !== 3'd4 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_limit: got %0d/%b want 4/0",
                  bus.fifo_count, bus.in_ready);
      end
      bus.lane_done = 4'b0001;
      step();
      bus.lane_done = 4'b0000;
      n_run++;
      if (bus.in_ready !== 1'b0 ||
          bus.fifo_count !== 3'd4) begin
         n_fail++;
         $display("FAIL full_nobypass: got %b/%0d want 0/4",
                  bus.in_ready, bus.fifo_count);
      end
      step();
      n_run++;
      if (bus.fifo_count !== 3'd3 ||
          bus.issue_valid !== 4'b0001) begin
         n_fail++;
         $display("FAIL full_pop: got %0d/%b want 3/0001",
                  bus.fifo_count, bus.issue_valid);
      end
      step();
      n_run++;
      if (bus.fifo_count !== 3'd4) begin
         n_fail++;
         $display("FAIL full_refill: got %0d want 4",
                  bus.fifo_count);
      end
      idle();
   endtask

   task automatic test_illegal();
      do_reset();
      set_in(1, 6, 9, 9, 4'b0011);
      step();
      idle();
      step();
      n_run++;
      if (bus.illegal_op !== 1'b1 ||
          bus.issue_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL illegal_pulse: got %b/%b want 1/0000",
                  bus.illegal_op, bus.issue_valid);
      end
      n_run++;
      if ({bus.issue_opcode, bus.issue_a, bus.issue_b}
          !== 19'd0) begin
         n_fail++;
         $display("FAIL illegal_bus: got %h want 0",
                  {bus.issue_opcode, bus.issue_a, bus.issue_b});
      end
      step();
      n_run++;
      if (bus.illegal_op !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_once: got %b want 0",
                  bus.illegal_op);
      end
      for (int i = 0; i < L; i++) begin
         n_run++;
         if (int'(dut.credit_q[i]) !== RS) begin
            n_fail++;
            $display("FAIL illegal_credit%0d: got %0d want %0d",
                     i, dut.credit_q[i], RS);
         end
      end
      set_in(1, 4, 8'hAA, 8'h55, 4'b0011);
      step();
      idle();
      step();
      n_run++;
      if (bus.issue_valid !== 4'b0011 ||
          bus.issue_opcode !== 3'd4 ||
          bus.issue_a !== 8'hAA) begin
         n_fail++;
         $display("FAIL illegal_next: got %b/%h/%h want 0011/4/aa",
                  bus.issue_valid, bus.issue_opcode, bus.issue_a);
      end
      set_in(1, 0, 1, 1, 4'b0000);
      step();
      idle();
      step();
      n_run++;
      if (bus.illegal_op !== 1'b1 ||
          bus.issue_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL illegal_mask0: got %b/%b want 1/0000",
                  bus.illegal_op, bus.issue_valid);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      set_in(1, 0, 7, 7, 4'b0100);
      step();
      bus.in_valid  = 1'b0;
      bus.lane_done = 4'b0100;
      step();
      bus.lane_done = 4'b0000;
      n_run++;
      if (bus.issue_valid !== 4'b0100 ||
          int'(dut.credit_q[2]) !== RS ||
          bus.credit_err !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_lane2: got %b/%0d/%b want 0100/4/0",
                  bus.issue_valid, dut.credit_q[2],
                  bus.credit_err);
      end
      bus.lane_done = 4'b0010;
      step();
      bus.lane_done = 4'b0000;
      n_run++;
      if (bus.credit_err !== 1'b1 ||
          int'(dut.credit_q[1]) !== RS) begin
         n_fail++;
         $display("FAIL simul_overflow: got %b/%0d want 1/4",
                  bus.credit_err, dut.credit_q[1]);
      end
      step();
      step();
      n_run++;
      if (bus.credit_err !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_sticky: got %b want 1",
                  bus.credit_err);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      for (int k = 0; k < 7; k++) begin
         set_in(1, 0, k, k, 4'b0001);
         bus.lane_done = (k == 6) ? 4'b1000 : 4'b0000;
         step();
      end
      idle();
      n_run++;
      if (bus.fifo_count !== 3'd3 ||
          bus.credit_err !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_setup: got %0d/%b want 3/1",
                  bus.fifo_count, bus.credit_err);
      end
      set_in(1, 0, 9, 9, 4'b0001);
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle();
      n_run++;
      if (bus.fifo_count !== 3'd0 ||
          bus.issue_valid !== 4'b0000 ||
          bus.credit_err !== 1'b0 ||
          bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset: got %0d/%b/%b/%b want 0/0000/0/1",
                  bus.fifo_count, bus.issue_valid,
                  bus.credit_err, bus.in_ready);
      end
      for (int i = 0; i < L; i++) begin
         n_run++;
         if (int'(dut.credit_q[i]) !== RS) begin
            n_fail++;
            $display("FAIL mid_credit%0d: got %0d want %0d",
                     i, dut.credit_q[i], RS);
         end
      end
      for (int k = 0; k < 3; k++) begin
         step();
         n_run++;
         if (bus.issue_valid !== 4'b0000 ||
             bus.fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_quiet%0d: got %b/%0d want 0000/0",
                     k, bus.issue_valid, bus.fifo_count);
         end
      end
   endtask

   task automatic test_random();
      int op;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         op = ($urandom_range(0, 9) < 8) ?
              $urandom_range(0, 4) : $urandom_range(5, 7);
         set_in($urandom_range(0, 9) < 7, op,
                $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 15));
         for (int i = 0; i < L; i++)
            bus.lane_done[i] = ($urandom_range(0, 2) == 0);
         reset = ($urandom_range(0, 99) == 0);
         n_run++;
         if (bus.in_ready !== (m_q.size() < D)) begin
            n_fail++;
            $display("FAIL rnd_ready c%0d: got %b want %b",
                     c, bus.in_ready, m_q.size() < D);
         end
         step();
         reset = 1'b0;
         n_run++;
         if (bus.issue_valid !== 4'(m_iv) ||
             bus.illegal_op !== m_ill) begin
            n_fail++;
            $display("FAIL rnd_issue c%0d: got %b/%b want %b/%b",
                     c, bus.issue_valid, bus.illegal_op,
                     4'(m_iv), m_ill);
         end
         n_run++;
         if ({bus.issue_opcode, bus.issue_a, bus.issue_b} !==
             {3'(m_op), 8'(m_a), 8'(m_b)}) begin
            n_fail++;
            $display("FAIL rnd_bus c%0d: got %h/%h/%h want %h/%h/%h",
                     c, bus.issue_opcode, bus.issue_a, bus.issue_b,
                     3'(m_op), 8'(m_a), 8'(m_b));
         end
         n_run++;
         if (bus.fifo_count !== 3'(m_q.size()) ||
             bus.credit_err !== m_err) begin
            n_fail++;
            $display("FAIL rnd_status c%0d: got %0d/%b want %0d/%b",
                     c, bus.fifo_count, bus.credit_err,
                     m_q.size(), m_err);
         end
         for (int i = 0; i < L; i++) begin
            n_run++;
            if (int'(dut.credit_q[i]) !== m_cred[i]) begin
               n_fail++;
               $display("FAIL rnd_credit%0d c%0d: got %0d want %0d",
                        i, c, dut.credit_q[i], m_cred[i]);
            end
         end
      end
      idle();
   endtask

   initial begin
      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_opcode = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_mask   = '0;
      bus.lane_done = '0;
      test_reset();
      test_basic_issue();
      test_credit_stall();
      test_fifo_full();
      test_illegal();
      test_simultaneous();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
